// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, control mask, flag register and FSM states.
// Optional multiplier is enabled by defining ALU_MC_MUL_EN.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    op_add = 3'd0,
    op_and = 3'd1,
    op_or  = 3'd2,
    op_not = 3'd3,
    op_rl  = 3'd4,
    op_rr  = 3'd5,
    op_mul = 3'd6
  } opcode_t;

  typedef struct packed {
    logic S;
    logic C;
  } ctl_t;

  typedef struct packed {
    logic S;
    logic Z;
    logic C;
    logic V;
  } flags_t;

  localparam int ALU_MC_STATE_W = 2;

  typedef enum logic [ALU_MC_STATE_W-1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_mc_state_t;

endpackage

// File: rtl/alu_rot_step.sv
// One-bit rotate step (left or right) through an external carry, with optional
// carry feed-in or arithmetic sign fill on right rotates.
module alu_rot_step
  import alu_mc_pkg::*;
#(
  parameter int width = 8
) (
  input  logic [width-1:0] acc,
  input  logic             c_in,
  input  logic             left,
  input  ctl_t             ctl,
  output logic [width-1:0] acc_nxt,
  output logic             c_nxt
);

  logic fill_lsb;
  logic fill_msb;

  assign fill_lsb = ctl.C ? c_in : 1'b0;
  assign fill_msb = ctl.C ? c_in : (ctl.S ? acc[width-1] : 1'b0);

  always_comb begin
    // NOTE: every output gets a value before any branch so no latch can be inferred.
    acc_nxt = acc;
    c_nxt   = c_in;
    if (left) begin
      acc_nxt = {acc[width-2:0], fill_lsb};
      c_nxt   = acc[width-1];
    end else begin
      acc_nxt = {fill_msb, acc[width-1:1]};
      c_nxt   = acc[0];
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, S/Z/C/V flag register and bit-serial rotates.
// Define ALU_MC_MUL_EN to build the shift-add multiplier for op_mul.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int width   = 8,
  parameter int SHAMT_W = $clog2(width) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  opcode_t            opcode,
  input  ctl_t               bmask,
  input  logic [width-1:0]   arg1,
  input  logic [width-1:0]   arg2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   dout,
  output logic [width-1:0]   dout_hi,
  output flags_t             flags
);

  localparam logic [SHAMT_W-1:0] WIDTH_CNT = SHAMT_W'(width);
  localparam logic [SHAMT_W-1:0] ONE_CNT   = SHAMT_W'(1);

  alu_mc_state_t state_q, state_d;

  opcode_t            op_q;
  ctl_t               ctl_q;
  logic [width-1:0]   a_q, b_q;
  logic               shamt_zero_q;
  logic [SHAMT_W-1:0] cnt_q, cnt_init;
  logic [width-1:0]   acc_q;
  logic               cw_q;

  logic [width-1:0]   dout_q, dout_hi_q;
  flags_t             flags_q;

  logic accept, last, is_rot;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last      = (state_q == EXEC) && (cnt_q == ONE_CNT);
  assign is_rot    = (op_q == op_rl) || (op_q == op_rr);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
  assign dout_hi   = dout_hi_q;
  assign flags     = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = EXEC;
      EXEC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cycle budget per op: rotates take their saturated count (min 1), mul one cycle per bit.
  always_comb begin
    cnt_init = ONE_CNT;
    case (opcode)
      op_rl, op_rr: begin
        if (shamt > WIDTH_CNT)  cnt_init = WIDTH_CNT;
        else if (shamt != '0)   cnt_init = shamt;
      end
`ifdef ALU_MC_MUL_EN
      op_mul:  cnt_init = WIDTH_CNT;
`endif
      default: cnt_init = ONE_CNT;
    endcase
  end

  logic [width-1:0] rot_acc;
  logic             rot_c;

  alu_rot_step #(.width(width)) u_rot_step (
    .acc     (acc_q),
    .c_in    (cw_q),
    .left    (op_q == op_rl),
    .ctl     (ctl_q),
    .acc_nxt (rot_acc),
    .c_nxt   (rot_c)
  );

  logic [width-1:0] b_eff;
  logic             add_cin;
  logic [width:0]   sum;

  assign b_eff   = ctl_q.S ? ~b_q : b_q;
  assign add_cin = ctl_q.S ? (ctl_q.C ? flags_q.C : 1'b1) : (ctl_q.C & flags_q.C);
  assign sum     = {1'b0, a_q} + {1'b0, b_eff} + {{width{1'b0}}, add_cin};

`ifdef ALU_MC_MUL_EN
  logic [width-1:0] mul_hi_q;
  logic [width:0]   mul_sum;
  logic [width-1:0] mul_hi_nxt, mul_lo_nxt;

  // acc_q holds the shrinking multiplier in its low bits while the product's low half shifts in.
  assign mul_sum    = {1'b0, mul_hi_q} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi_nxt = mul_sum[width:1];
  assign mul_lo_nxt = {mul_sum[0], acc_q[width-1:1]};
`endif

  logic [width-1:0] res_lo, res_hi;
  flags_t           res_flags;

  always_comb begin
    res_lo    = '0;
    res_hi    = '0;
    res_flags = flags_q;
    case (op_q)
      op_add: begin
        res_lo      = sum[width-1:0];
        res_flags.C = sum[width];
        res_flags.V = (a_q[width-1] == b_eff[width-1]) && (sum[width-1] != a_q[width-1]);
      end
      op_and: begin
        res_lo      = a_q & b_q;
        res_flags.C = 1'b0;
        res_flags.V = 1'b0;
      end
      op_or: begin
        res_lo      = a_q | b_q;
        res_flags.C = 1'b0;
        res_flags.V = 1'b0;
      end
      op_not: begin
        res_lo      = ~b_q;
        res_flags.C = 1'b0;
        res_flags.V = 1'b0;
      end
      op_rl, op_rr: begin
        res_lo      = shamt_zero_q ? a_q : rot_acc;
        res_flags.C = shamt_zero_q ? flags_q.C : rot_c;
        res_flags.V = 1'b0;
      end
`ifdef ALU_MC_MUL_EN
      op_mul: begin
        res_lo      = mul_lo_nxt;
        res_hi      = mul_hi_nxt;
        res_flags.C = |mul_hi_nxt;
        res_flags.V = |mul_hi_nxt;
      end
`endif
      default: begin
        res_lo    = '0;
        res_flags = flags_q;
      end
    endcase
    if (op_q == op_add || op_q == op_and || op_q == op_or || op_q == op_not || is_rot) begin
      res_flags.S = res_lo[width-1];
      res_flags.Z = (res_lo == '0);
    end
`ifdef ALU_MC_MUL_EN
    if (op_q == op_mul) begin
      res_flags.S = res_lo[width-1];
      res_flags.Z = ({res_hi, res_lo} == '0);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: working registers are reset too, so an op aborted by reset leaves nothing stale behind.
      op_q         <= op_add;
      ctl_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      shamt_zero_q <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      cw_q         <= 1'b0;
      dout_q       <= '0;
      dout_hi_q    <= '0;
      flags_q      <= '0;
`ifdef ALU_MC_MUL_EN
      mul_hi_q     <= '0;
`endif
    end else if (accept) begin
      op_q         <= opcode;
      ctl_q        <= bmask;
      a_q          <= arg1;
      b_q          <= arg2;
      shamt_zero_q <= (shamt == '0);
      cnt_q        <= cnt_init;
      cw_q         <= flags_q.C;
`ifdef ALU_MC_MUL_EN
      acc_q        <= (opcode == op_mul) ? arg2 : arg1;
      mul_hi_q     <= '0;
`else
      acc_q        <= arg1;
`endif
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q - ONE_CNT;
      if (is_rot && !shamt_zero_q) begin
        acc_q <= rot_acc;
        cw_q  <= rot_c;
      end
`ifdef ALU_MC_MUL_EN
      if (op_q == op_mul) begin
        acc_q    <= mul_lo_nxt;
        mul_hi_q <= mul_hi_nxt;
      end
`endif
      if (last) begin
        dout_q    <= res_lo;
        dout_hi_q <= res_hi;
        flags_q   <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: a reference model pushes expected results
// to a scoreboard queue at issue time; they are popped and compared when out_valid rises.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W  = 8;
  localparam int SW = $clog2(W) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  opcode_t       opcode;
  ctl_t          bmask;
  logic [W-1:0]  arg1, arg2;
  logic [SW-1:0] shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout, dout_hi;
  flags_t        flags;

  alu_mc #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .bmask     (bmask),
    .arg1      (arg1),
    .arg2      (arg2),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .dout_hi   (dout_hi),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    flags_t       f;
    int           lat;
  } exp_t;

  exp_t   sb[$];
  flags_t model_flags;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input opcode_t op, input ctl_t c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [SW-1:0] sh, input flags_t fin);
    exp_t         e;
    logic [W-1:0] bb, acc;
    logic [W:0]   s;
    logic [15:0]  p;
    logic         cy, cin, msb, nc, known;
    int           sv, n;
    e.lo = '0; e.hi = '0; e.f = fin; e.lat = 1; known = 1'b1;
    case (op)
      op_add: begin
        bb  = c.S ? ~b : b;
        cin = c.S ? (c.C ? fin.C : 1'b1) : (c.C & fin.C);
        s   = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
        sv  = int'($signed(a)) + int'($signed(bb)) + int'(cin);
        e.lo = s[W-1:0]; e.f.C = s[W]; e.f.V = (sv > 127) || (sv < -128);
      end
      op_and: begin e.lo = a & b; e.f.C = 1'b0; e.f.V = 1'b0; end
      op_or:  begin e.lo = a | b; e.f.C = 1'b0; e.f.V = 1'b0; end
      op_not: begin e.lo = ~b;    e.f.C = 1'b0; e.f.V = 1'b0; end
      op_rl, op_rr: begin
        n = (int'(sh) > W) ? W : int'(sh);
        e.lat = (n == 0) ? 1 : n;
        acc = a; cy = fin.C;
        for (int i = 0; i < n; i++) begin
          if (op == op_rl) begin
            {cy, acc} = {acc, (c.C ? cy : 1'b0)};
          end else begin
            msb = c.C ? cy : (c.S ? acc[W-1] : 1'b0);
            nc  = acc[0];
            acc = {msb, acc[W-1:1]};
            cy  = nc;
          end
        end
        e.lo = acc; e.f.C = cy; e.f.V = 1'b0;
      end
`ifdef ALU_MC_MUL_EN
      op_mul: begin
        p = {8'd0, a} * {8'd0, b};
        e.lo = p[7:0]; e.hi = p[15:8]; e.lat = W;
        e.f.C = (p[15:8] != 0); e.f.V = (p[15:8] != 0);
        e.f.S = p[7]; e.f.Z = (p == 0);
        known = 1'b0;
      end
`endif
      default: known = 1'b0;
    endcase
    if (known) begin
      e.f.S = e.lo[W-1];
      e.f.Z = (e.lo == 0);
    end
    return e;
  endfunction

  // Issue one op, wait for its result, optionally stall the consumer, then drain.
  task automatic run_op(input string tag, input opcode_t op, input ctl_t c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] sh, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, c, a, b, sh, model_flags));
    check({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    opcode = op; bmask = c; arg1 = a; arg2 = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      out_ready = 1'b0;
    end
    out_ready = 1'b0;
    e = sb.pop_front();
    model_flags = e.f;
    check({tag, ".lat"},     16'(lat),     16'(e.lat));
    check({tag, ".dout"},    16'(dout),    16'(e.lo));
    check({tag, ".dout_hi"}, 16'(dout_hi), 16'(e.hi));
    check({tag, ".flags"},   16'(flags),   16'(e.f));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; opcode = op_and; arg1 = 8'h00; arg2 = 8'h00;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 16'(out_valid), 16'd1);
      check({tag, ".hold_ready"}, 16'(in_ready),  16'd0);
      check({tag, ".hold_dout"},  16'(dout),      16'(e.lo));
      check({tag, ".hold_flags"}, 16'(flags),     16'(e.f));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drained"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = op_add; bmask = '0; arg1 = '0; arg2 = '0; shamt = '0;
    model_flags = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst.in_ready",  16'(in_ready),  16'd1);
    check("rst.out_valid", 16'(out_valid), 16'd0);
    check("rst.dout",      16'(dout),      16'd0);
    check("rst.dout_hi",   16'(dout_hi),   16'd0);
    check("rst.flags",     16'(flags),     16'd0);

    run_op("add_ovf",  op_add, '{S:1'b0, C:1'b0}, 8'h7F, 8'h01, 4'd0, 0);
    check("add_ovf.spec", 16'({dout, flags}), 16'({8'h80, 4'b1001}));
    run_op("sub_zero", op_add, '{S:1'b1, C:1'b0}, 8'h05, 8'h05, 4'd0, 0);
    check("sub_zero.spec", 16'({dout, flags}), 16'({8'h00, 4'b0110}));
    run_op("adc",      op_add, '{S:1'b0, C:1'b1}, 8'hF0, 8'h0F, 4'd0, 0);
    run_op("sbb",      op_add, '{S:1'b1, C:1'b1}, 8'h80, 8'h01, 4'd0, 0);
    run_op("rr_arith", op_rr,  '{S:1'b1, C:1'b0}, 8'b1000_0001, 8'h00, 4'd3, 0);
    check("rr_arith.spec", 16'({dout, flags.C}), 16'({8'hF0, 1'b0}));
    run_op("and",      op_and, '{S:1'b0, C:1'b0}, 8'hCA, 8'h0F, 4'd0, 0);
    run_op("or",       op_or,  '{S:1'b0, C:1'b0}, 8'h80, 8'h01, 4'd0, 0);
    run_op("not",      op_not, '{S:1'b0, C:1'b0}, 8'h00, 8'hFF, 4'd0, 0);
    run_op("rl_c_sat", op_rl,  '{S:1'b0, C:1'b1}, 8'hA5, 8'h00, 4'd12, 0);
    run_op("rl_shift", op_rl,  '{S:1'b0, C:1'b0}, 8'hC3, 8'h00, 4'd2, 0);
    run_op("rr_c",     op_rr,  '{S:1'b0, C:1'b1}, 8'h01, 8'h00, 4'd1, 0);
    run_op("rr_zero",  op_rr,  '{S:1'b1, C:1'b0}, 8'h96, 8'h00, 4'd0, 0);
    run_op("rl_full",  op_rl,  '{S:1'b0, C:1'b1}, 8'h3C, 8'h00, 4'd8, 0);
    run_op("mul_ff",   op_mul, '{S:1'b0, C:1'b0}, 8'hFF, 8'hFF, 4'd0, 0);
    run_op("mul_mid",  op_mul, '{S:1'b0, C:1'b0}, 8'h0D, 8'h0B, 4'd0, 0);
    run_op("unknown",  opcode_t'(3'd7), '{S:1'b1, C:1'b1}, 8'h55, 8'hAA, 4'd3, 0);
    run_op("hold",     op_add, '{S:1'b0, C:1'b0}, 8'h40, 8'h41, 4'd0, 5);
    for (int k = 0; k < 6; k++) begin
      run_op("loop_add", op_add, ctl_t'(2'($urandom_range(3))), 8'($urandom), 8'($urandom), 4'd0, 0);
    end

    opcode = op_rl; bmask = '{S:1'b0, C:1'b1}; arg1 = 8'hF0; shamt = 4'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 16'(out_valid), 16'd0);
    check("rst_mid.flags",     16'(flags),     16'd0);
    check("rst_mid.dout",      16'(dout),      16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_flags = '0;
    check("rst_mid.in_ready",  16'(in_ready),  16'd1);
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid.no_result", 16'(out_valid), 16'd0);
    run_op("post_rst", op_or, '{S:1'b0, C:1'b0}, 8'h00, 8'h00, 4'd0, 0);
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
